// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the fetch stage: widths, defaults, FSM encoding
// and the queue entry layout.
package inst_fetcher_pkg;

    localparam int WORD_W = 32;
    localparam int IQ_SIZE_LOG_DEF = 4;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0;

    typedef enum logic [1:0] {
        IF_IDLE     = 2'd0,
        IF_WAIT_MEM = 2'd1,
        IF_DISCARD  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/inst_fetcher_if.sv
// Memory-request and decoder-side signals of the fetch stage.
// Both are valid/ready style: mem_req_out is a level held until a one-cycle
// mem_done_in; a queue head moves only when iq_valid_out && iq_ready_in.
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic              mem_req_out;
    logic [WORD_W-1:0] mem_addr_out;
    logic              mem_done_in;
    logic [WORD_W-1:0] mem_inst_in;
    logic              iq_valid_out;
    logic [WORD_W-1:0] iq_inst_out;
    logic [WORD_W-1:0] iq_pc_out;
    logic              iq_ready_in;

    modport master (
        output mem_req_out, mem_addr_out,
        input  mem_done_in, mem_inst_in,
        output iq_valid_out, iq_inst_out, iq_pc_out,
        input  iq_ready_in
    );

    modport slave (
        input  mem_req_out, mem_addr_out,
        output mem_done_in, mem_inst_in,
        input  iq_valid_out, iq_inst_out, iq_pc_out,
        output iq_ready_in
    );

endinterface

// File: rtl/inst_queue.sv
// Circular FIFO of fetched words with synchronous clear; head is read
// combinationally and forced to zero while the queue is empty.
module inst_queue #(
    parameter int LOG = 4,
    parameter int W   = 64
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         en_in,
    input  logic         clear_in,
    input  logic         push_in,
    input  logic         pop_in,
    input  logic [W-1:0] wdata_in,
    output logic [W-1:0] rdata_out,
    output logic [LOG:0] count_out,
    output logic         full_out,
    output logic         empty_out
);

    localparam int DEPTH = 1 << LOG;
    localparam logic [LOG:0] DEPTH_CNT = (LOG+1)'(DEPTH);

    logic [LOG-1:0] head_q, tail_q;
    logic [LOG:0]   count_q;
    logic [W-1:0]   mem_q [DEPTH];
    logic           do_push, do_pop;

    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == DEPTH_CNT);
    assign count_out = count_q;
    assign rdata_out = empty_out ? '0 : mem_q[head_q];

    // A pop in the same cycle frees the slot, so push into a full queue is legal then.
    assign do_pop  = en_in && !clear_in && pop_in && !empty_out;
    assign do_push = en_in && !clear_in && push_in && (!full_out || do_pop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en_in) begin
            if (clear_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) tail_q <= tail_q + 1'b1;
                if (do_pop)  head_q <= head_q + 1'b1;
                count_q <= count_q + {{LOG{1'b0}}, do_push} - {{LOG{1'b0}}, do_pop};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[tail_q] <= wdata_in;
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: owns the fetch PC, keeps one memory request outstanding and
// buffers returned words with their PCs for the decoder.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int                IQ_SIZE_LOG = IQ_SIZE_LOG_DEF,
    parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic [WORD_W-1:0]    clear_pc_in,
    inst_fetcher_if.master       fetch_bus,
    output if_state_e            dbg_state_out,
    output logic [WORD_W-1:0]    dbg_pc_out,
    output logic [IQ_SIZE_LOG:0] dbg_count_out
);

    localparam logic [IQ_SIZE_LOG:0] DEPTH_CNT = (IQ_SIZE_LOG+1)'(1 << IQ_SIZE_LOG);

    if_state_e            state_q;
    logic [WORD_W-1:0]    pc_q, addr_q, pc_inc_d;
    logic                 req_q;
    logic                 do_push, do_pop, iq_full, iq_empty;
    logic [IQ_SIZE_LOG:0] iq_count, post_cnt_d;
    iq_entry_t            push_entry, head_entry;

    assign do_push    = (state_q == IF_WAIT_MEM) && fetch_bus.mem_done_in && !clear_in;
    assign do_pop     = !iq_empty && fetch_bus.iq_ready_in && !clear_in;
    assign pc_inc_d   = pc_q + 32'd4;
    assign post_cnt_d = iq_count + 1'b1 - {{IQ_SIZE_LOG{1'b0}}, do_pop};
    assign push_entry = '{pc: pc_q, inst: fetch_bus.mem_inst_in};

    inst_queue #(
        .LOG (IQ_SIZE_LOG),
        .W   ($bits(iq_entry_t))
    ) u_queue (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .en_in     (rdy_in),
        .clear_in  (clear_in),
        .push_in   (do_push),
        .pop_in    (do_pop),
        .wdata_in  (push_entry),
        .rdata_out (head_entry),
        .count_out (iq_count),
        .full_out  (iq_full),
        .empty_out (iq_empty)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IF_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                pc_q <= clear_pc_in;
                // An in-flight request must still complete; its word is dropped in DISCARD.
                if (state_q != IF_IDLE) begin
                    if (fetch_bus.mem_done_in) begin
                        state_q <= IF_IDLE;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= IF_DISCARD;
                    end
                end
            end else begin
                case (state_q)
                    IF_IDLE: begin
                        if (!iq_full) begin
                            state_q <= IF_WAIT_MEM;
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                        end
                    end
                    IF_WAIT_MEM: begin
                        if (fetch_bus.mem_done_in) begin
                            pc_q <= pc_inc_d;
                            if (post_cnt_d < DEPTH_CNT) begin
                                addr_q <= pc_inc_d;
                            end else begin
                                state_q <= IF_IDLE;
                                req_q   <= 1'b0;
                            end
                        end
                    end
                    IF_DISCARD: begin
                        if (fetch_bus.mem_done_in) begin
                            state_q <= IF_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IF_IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fetch_bus.mem_req_out  = req_q;
    assign fetch_bus.mem_addr_out = addr_q;
    assign fetch_bus.iq_valid_out = !iq_empty;
    assign fetch_bus.iq_inst_out  = head_entry.inst;
    assign fetch_bus.iq_pc_out    = head_entry.pc;

    assign dbg_state_out = state_q;
    assign dbg_pc_out    = pc_q;
    assign dbg_count_out = iq_count;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: a vector table for the basic fetch stream
// plus hand-written sequences for full queue, redirect, pause and reset.
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clear_in;
    logic [31:0] clear_pc_in;
    if_state_e   dbg_state;
    logic [31:0] dbg_pc;
    logic [4:0]  dbg_count;

    inst_fetcher_if bus ();

    inst_fetcher #(
        .IQ_SIZE_LOG (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .clear_pc_in   (clear_pc_in),
        .fetch_bus     (bus),
        .dbg_state_out (dbg_state),
        .dbg_pc_out    (dbg_pc),
        .dbg_count_out (dbg_count)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    typedef struct {
        logic        done;
        logic [31:0] inst;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_mem(input logic done, input logic [31:0] inst, input logic ready);
        bus.mem_done_in = done;
        bus.mem_inst_in = inst;
        bus.iq_ready_in = ready;
    endtask

    task automatic check_head(input string name, input logic [63:0] e);
        check({name, " valid"}, 32'(bus.iq_valid_out), 32'd1);
        check({name, " pc"}, bus.iq_pc_out, e[63:32]);
        check({name, " inst"}, bus.iq_inst_out, e[31:0]);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0, 2'd1};
        vecs[1] = '{1'b1, 32'h00500093, 1'b1, 1'b1, 32'h4, 1'b1, 32'h00500093, 32'h0, 2'd1};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h4, 1'b0, 32'h0,        32'h0, 2'd1};
        vecs[3] = '{1'b1, 32'h00100113, 1'b1, 1'b1, 32'h8, 1'b1, 32'h00100113, 32'h4, 2'd1};
        vecs[4] = '{1'b1, 32'h002081B3, 1'b1, 1'b1, 32'hC, 1'b1, 32'h002081B3, 32'h8, 2'd1};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hC, 1'b0, 32'h0,        32'h0, 2'd1};

        rst_n_in    = 1'b0;
        rdy_in      = 1'b1;
        clear_in    = 1'b0;
        clear_pc_in = 32'h0;
        drive_mem(1'b0, 32'h0, 1'b1);
        step();
        step();
        check("rst state", 32'(dbg_state), 32'(IF_IDLE));
        check("rst pc", dbg_pc, 32'h0);
        check("rst count", 32'(dbg_count), 32'd0);
        check("rst req", 32'(bus.mem_req_out), 32'd0);
        check("rst addr", bus.mem_addr_out, 32'h0);
        check("rst valid", 32'(bus.iq_valid_out), 32'd0);
        check("rst iq_inst", bus.iq_inst_out, 32'h0);
        check("rst iq_pc", bus.iq_pc_out, 32'h0);
        rst_n_in = 1'b1;

        // Basic stream with consumer ready
        for (int i = 0; i < 6; i++) begin
            drive_mem(vecs[i].done, vecs[i].inst, vecs[i].ready);
            step();
            check($sformatf("v%0d req", i), 32'(bus.mem_req_out), 32'(vecs[i].exp_req));
            check($sformatf("v%0d addr", i), bus.mem_addr_out, vecs[i].exp_addr);
            check($sformatf("v%0d valid", i), 32'(bus.iq_valid_out), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d iq_inst", i), bus.iq_inst_out, vecs[i].exp_inst);
            check($sformatf("v%0d iq_pc", i), bus.iq_pc_out, vecs[i].exp_pc);
            check($sformatf("v%0d state", i), 32'(dbg_state), 32'(vecs[i].exp_state));
        end

        // Consumer stalled: fill the queue from reset
        rst_n_in = 1'b0;
        drive_mem(1'b0, 32'h0, 1'b0);
        #2;
        rst_n_in = 1'b1;
        step();
        check("stall first addr", bus.mem_addr_out, 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive_mem(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
            if (i < 16) exp_q.push_back({32'(i * 4), 32'hA000_0000 + 32'(i)});
            step();
        end
        drive_mem(1'b0, 32'h0, 1'b0);
        check("full count", 32'(dbg_count), 32'd16);
        check("full req", 32'(bus.mem_req_out), 32'd0);
        check("full pc", dbg_pc, 32'h40);
        check("full state", 32'(dbg_state), 32'(IF_IDLE));
        check_head("full head", exp_q[0]);

        drive_mem(1'b0, 32'h0, 1'b1);
        step();
        void'(exp_q.pop_front());
        drive_mem(1'b0, 32'h0, 1'b0);
        check("pop1 count", 32'(dbg_count), 32'd15);
        check("pop1 req", 32'(bus.mem_req_out), 32'd0);
        step();
        check("refetch req", 32'(bus.mem_req_out), 32'd1);
        check("refetch addr", bus.mem_addr_out, 32'h40);
        check("refetch state", 32'(dbg_state), 32'(IF_WAIT_MEM));
        check_head("refetch head", exp_q[0]);

        // Simultaneous push and pop, then push to full, then drain in order
        drive_mem(1'b1, 32'hB000_0010, 1'b1);
        step();
        void'(exp_q.pop_front());
        exp_q.push_back({32'h40, 32'hB000_0010});
        check("pp count", 32'(dbg_count), 32'd15);
        check("pp addr", bus.mem_addr_out, 32'h44);
        check("pp state", 32'(dbg_state), 32'(IF_WAIT_MEM));
        drive_mem(1'b1, 32'hB000_0011, 1'b0);
        step();
        exp_q.push_back({32'h44, 32'hB000_0011});
        check("push16 count", 32'(dbg_count), 32'd16);
        check("push16 state", 32'(dbg_state), 32'(IF_IDLE));
        check("push16 req", 32'(bus.mem_req_out), 32'd0);
        check("push16 pc", dbg_pc, 32'h48);
        drive_mem(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (exp_q.size() == 0) begin
                check("drain underflow", 32'(exp_q.size()), 32'd1);
                break;
            end
            exp_e = exp_q.pop_front();
            check_head($sformatf("drain%0d", i), exp_e);
            step();
        end
        check("drained valid", 32'(bus.iq_valid_out), 32'd0);
        check("drained addr", bus.mem_addr_out, 32'h48);

        // Redirect while a request is outstanding
        drive_mem(1'b0, 32'h0, 1'b1);
        clear_in    = 1'b1;
        clear_pc_in = 32'h1000;
        step();
        clear_in = 1'b0;
        check("clr state", 32'(dbg_state), 32'(IF_DISCARD));
        check("clr req", 32'(bus.mem_req_out), 32'd1);
        check("clr addr", bus.mem_addr_out, 32'h48);
        check("clr pc", dbg_pc, 32'h1000);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("disc%0d state", i), 32'(dbg_state), 32'(IF_DISCARD));
            check($sformatf("disc%0d valid", i), 32'(bus.iq_valid_out), 32'd0);
        end
        drive_mem(1'b1, 32'hDEAD_BEEF, 1'b1);
        step();
        drive_mem(1'b0, 32'h0, 1'b1);
        check("drop valid", 32'(bus.iq_valid_out), 32'd0);
        check("drop req", 32'(bus.mem_req_out), 32'd0);
        check("drop state", 32'(dbg_state), 32'(IF_IDLE));
        step();
        check("restart req", 32'(bus.mem_req_out), 32'd1);
        check("restart addr", bus.mem_addr_out, 32'h1000);
        check("restart valid", 32'(bus.iq_valid_out), 32'd0);

        // Redirect coincident with done and pop
        drive_mem(1'b1, 32'h1111_1111, 1'b0);
        step();
        check("c5 count", 32'(dbg_count), 32'd1);
        check_head("c5 head", {32'h1000, 32'h1111_1111});
        check("c5 addr", bus.mem_addr_out, 32'h1004);
        drive_mem(1'b1, 32'h2222_2222, 1'b1);
        clear_in    = 1'b1;
        clear_pc_in = 32'h2000;
        step();
        clear_in = 1'b0;
        drive_mem(1'b0, 32'h0, 1'b0);
        check("c5 clr valid", 32'(bus.iq_valid_out), 32'd0);
        check("c5 clr count", 32'(dbg_count), 32'd0);
        check("c5 clr state", 32'(dbg_state), 32'(IF_IDLE));
        check("c5 clr req", 32'(bus.mem_req_out), 32'd0);
        check("c5 clr pc", dbg_pc, 32'h2000);
        step();
        check("c5 restart req", 32'(bus.mem_req_out), 32'd1);
        check("c5 restart addr", bus.mem_addr_out, 32'h2000);

        // Pause: everything frozen, clear ignored
        drive_mem(1'b1, 32'h3333_3333, 1'b0);
        step();
        check("p count", 32'(dbg_count), 32'd1);
        rdy_in = 1'b0;
        drive_mem(1'b0, 32'h0, 1'b1);
        clear_pc_in = 32'h3000;
        for (int i = 0; i < 5; i++) begin
            clear_in = (i == 2);
            step();
            check($sformatf("p%0d state", i), 32'(dbg_state), 32'(IF_WAIT_MEM));
            check($sformatf("p%0d pc", i), dbg_pc, 32'h2004);
            check($sformatf("p%0d count", i), 32'(dbg_count), 32'd1);
            check($sformatf("p%0d addr", i), bus.mem_addr_out, 32'h2004);
            check($sformatf("p%0d inst", i), bus.iq_inst_out, 32'h3333_3333);
        end
        clear_in = 1'b0;
        rdy_in   = 1'b1;
        drive_mem(1'b1, 32'h4444_4444, 1'b0);
        step();
        drive_mem(1'b0, 32'h0, 1'b0);
        check("resume count", 32'(dbg_count), 32'd2);
        check("resume pc", dbg_pc, 32'h2008);
        check_head("resume head", {32'h2000, 32'h3333_3333});

        // Asynchronous reset mid-request
        #2;
        rst_n_in = 1'b0;
        #1;
        check("arst req", 32'(bus.mem_req_out), 32'd0);
        check("arst addr", bus.mem_addr_out, 32'h0);
        check("arst state", 32'(dbg_state), 32'(IF_IDLE));
        check("arst valid", 32'(bus.iq_valid_out), 32'd0);
        check("arst pc", dbg_pc, 32'h0);
        check("arst count", 32'(dbg_count), 32'd0);
        check("arst iq_pc", bus.iq_pc_out, 32'h0);
        step();
        rst_n_in = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
